// File: rtl/bcd_display_scan.sv
// bcd_display_scan: scans a frame-coherent BCD time snapshot onto a 4-digit common-anode 7-segment display.
// Optional macro DIM_PWM_EN adds a 3-bit dim input that PWM-gates the active anode and the colon.
module bcd_display_scan #(
  parameter int REFRESH_DIV  = 250,
  parameter int GUARD_CYC    = 4,
  parameter int BLINK_FRAMES = 500,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hour1,
  input  logic [3:0] hour2,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
`ifdef DIM_PWM_EN
  input  logic [2:0] dim,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick,
  output logic       bcd_err
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYC);
  localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_frame;
  logic          r_colon;
  logic [15:0]   r_snap;

  logic          w_idle, w_term, w_wrap, w_blink, w_cap, w_blank, w_live, w_pwm;
  logic [1:0]    w_idx_n;
  logic [CW-1:0] w_cnt_n;
  logic [FW-1:0] w_frame_n;
  logic          w_colon_n;
  logic [15:0]   w_snap_n;
  logic [3:0]    w_digit;
  logic [3:0]    w_an_n;
  logic          w_dp_n;
  logic          w_err_n;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

`ifdef DIM_PWM_EN
  logic [2:0] r_pwm;
  logic [2:0] w_pwm_n;
  assign w_pwm_n = r_pwm + 3'd1;
  assign w_pwm   = w_pwm_n <= dim;
  // free-running brightness phase; compared against its next value so the registered anode lines up with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= w_pwm_n;
`else
  assign w_pwm = 1'b1;
`endif

  // next scan position, snapshot and colon state; outputs are decoded from these so they align with the registered state
  always_comb begin
    w_idle    = r_state == S_IDLE;
    w_term    = r_cnt == CNT_MAX;
    w_wrap    = !w_idle && w_term && r_idx == 2'd0;
    w_blink   = w_wrap && r_frame == FR_MAX;
    w_cap     = w_idle || w_wrap;
    w_cnt_n   = (w_idle || w_term) ? '0 : r_cnt + 1'b1;
    w_idx_n   = w_idle ? 2'd3 : (w_term ? r_idx - 2'd1 : r_idx);
    w_snap_n  = w_cap ? {hour1, hour2, min1, min2} : r_snap;
    w_frame_n = w_blink ? '0 : (w_wrap ? r_frame + 1'b1 : r_frame);
    w_colon_n = w_blink ? ~r_colon : r_colon;
    w_digit   = w_snap_n[{w_idx_n, 2'b00} +: 4];
    w_blank   = BLANK_LZ && w_idx_n == 2'd3 && w_digit == 4'd0;
    w_live    = w_cnt_n >= GUARD && w_pwm;
    w_an_n    = (w_live && !w_blank) ? ~(4'b0001 << w_idx_n) : 4'hF;
    w_dp_n    = !(w_live && w_idx_n == 2'd2 && w_colon_n);
    w_err_n   = w_snap_n[15:12] > 4'd9 || w_snap_n[11:8] > 4'd9 || w_snap_n[7:4] > 4'd9 || w_snap_n[3:0] > 4'd9;
  end

  // scan FSM with registered display outputs; reset blanks the display immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd3;
      r_cnt      <= '0;
      r_frame    <= '0;
      r_colon    <= 1'b1;
      r_snap     <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      r_state    <= S_SCAN;
      r_idx      <= w_idx_n;
      r_cnt      <= w_cnt_n;
      r_frame    <= w_frame_n;
      r_colon    <= w_colon_n;
      r_snap     <= w_snap_n;
      an         <= w_an_n;
      seg        <= seg_decode(w_digit);
      dp         <= w_dp_n;
      frame_tick <= w_cap;
      bcd_err    <= w_err_n;
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: scoreboard bench; stimulus queues the expected frame, a monitor checks every cycle of each frame.
module tb_bcd_display_scan;
  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      blank;
    logic            colon;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] hour1 = 4'd0, hour2 = 4'd0, min1 = 4'd0, min2 = 4'd0;
  logic [3:0] an, an0;
  logic [6:0] seg, seg0;
  logic dp, dp0, ft, ft0, err, err0;
  int n_chk = 0;
  int n_err = 0;
  bit mon_done = 1'b0;
  exp_t q[$];
  logic [15:0] vin [6];
  exp_t vexp [6];

  always #5 clk = ~clk;

  bcd_display_scan #(.REFRESH_DIV(8), .GUARD_CYC(2), .BLINK_FRAMES(2), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
`ifdef DIM_PWM_EN
    .dim(3'd7),
`endif
    .an(an), .seg(seg), .dp(dp), .frame_tick(ft), .bcd_err(err));

  bcd_display_scan #(.REFRESH_DIV(8), .GUARD_CYC(2), .BLINK_FRAMES(2), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
`ifdef DIM_PWM_EN
    .dim(3'd7),
`endif
    .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0), .bcd_err(err0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : monitor
    exp_t e;
    @(posedge rst_n);
    @(negedge clk);
    chk("first_tick", ft, 1);
    for (int f = 0; f < 7; f++) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard: no expected frame queued for frame %0d", f);
        e = '0;
      end else e = q.pop_front();
      for (int c = 0; c < 32; c++) begin
        int idx;
        int cn;
        logic [3:0] xa;
        idx = 3 - c / 8;
        cn  = c % 8;
        xa  = (cn < 2) ? 4'hF : ~(4'b0001 << idx);
        chk("frame_tick", ft, (c == 0) ? 1 : 0);
        chk("seg", seg, e.seg[idx]);
        chk("an", an, e.blank[idx] ? 4'hF : xa);
        chk("dp", dp, (idx == 2 && cn >= 2 && e.colon) ? 0 : 1);
        chk("bcd_err", err, e.err);
        chk("seg_nolz", seg0, e.seg[idx]);
        chk("an_nolz", an0, xa);
        @(negedge clk);
      end
    end
    mon_done = 1'b1;
  end

  initial begin : stim
    vin[0] = 16'h0059; vexp[0] = '{seg: {7'h40, 7'h40, 7'h12, 7'h10}, blank: 4'b1000, colon: 1'b1, err: 1'b0};
    vin[1] = 16'h235C; vexp[1] = '{seg: {7'h24, 7'h30, 7'h12, 7'h3F}, blank: 4'b0000, colon: 1'b0, err: 1'b1};
    vin[2] = 16'h2355; vexp[2] = '{seg: {7'h24, 7'h30, 7'h12, 7'h12}, blank: 4'b0000, colon: 1'b0, err: 1'b0};
    vin[3] = 16'h19A7; vexp[3] = '{seg: {7'h79, 7'h10, 7'h3F, 7'h78}, blank: 4'b0000, colon: 1'b1, err: 1'b1};
    vin[4] = 16'h0860; vexp[4] = '{seg: {7'h40, 7'h00, 7'h02, 7'h40}, blank: 4'b1000, colon: 1'b1, err: 1'b0};
    vin[5] = 16'hF000; vexp[5] = '{seg: {7'h3F, 7'h40, 7'h40, 7'h40}, blank: 4'b0000, colon: 1'b0, err: 1'b1};
    {hour1, hour2, min1, min2} = 16'h1234;
    q.push_back('{seg: {7'h79, 7'h24, 7'h30, 7'h19}, blank: 4'b0000, colon: 1'b1, err: 1'b0});
    repeat (3) @(negedge clk);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1);
    chk("reset_tick", ft, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      repeat (12) @(negedge clk);
      {hour1, hour2, min1, min2} = vin[v];
      q.push_back(vexp[v]);
      repeat (20) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    {hour1, hour2, min1, min2} = 16'h9999;
    repeat (20) @(negedge clk);
    #1;
    chk("monitor_done", {31'd0, mon_done}, 1);
    chk("f7_tick", ft, 1);
    chk("f7_seg", seg, 7'h10);
    chk("f7_err", err, 0);
    repeat (4) @(negedge clk);
    chk("pre_reset_an", an, 4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_an", an, 4'hF);
    chk("async_reset_seg", seg, 7'h7F);
    chk("async_reset_dp", dp, 1);
    chk("async_reset_tick", ft, 0);
    chk("async_reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_tick", ft, 1);
    chk("rerelease_seg", seg, 7'h10);
    chk("rerelease_an", an, 4'hF);
    repeat (31) @(negedge clk);
    chk("tick_gap", ft, 0);
    @(negedge clk);
    chk("tick_period", ft, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
